// File: rtl/frame_lock_monitor.sv
// rtl/frame_lock_monitor.sv - frame-lock FSM driven by match / not_match pulses
// Tracks hunt/confirm/locked/flywheel, emits lock events and saturating statistics.
module frame_lock_monitor #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match,
  input  logic             not_match,
  input  logic             clr,
  output logic             locked,
  output logic             lock_acq,
  output logic             lock_lost,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_CONFIRM  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FLYWHEEL = 2'd3
  } state_t;

  localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             lock_acq_q, lock_acq_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic       ev_m;
  logic       ev_x;
  logic [3:0] run_inc;

  // A coincident match/not_match is resolved as a mismatch.
  assign ev_m    = match & ~not_match;
  assign ev_x    = not_match;
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    lock_acq_d  = 1'b0;
    lock_lost_d = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (ev_m) begin
          if (LOCK_N == 4'd1) begin
            state_d    = ST_LOCKED;
            lock_acq_d = 1'b1;
            run_d      = 4'd0;
          end else begin
            state_d = ST_CONFIRM;
            run_d   = 4'd1;
          end
        end else if (ev_x) begin
          run_d = 4'd0;
        end
      end
      ST_CONFIRM: begin
        if (ev_m) begin
          if (run_inc == LOCK_N) begin
            state_d    = ST_LOCKED;
            lock_acq_d = 1'b1;
            run_d      = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end else if (ev_x) begin
          state_d = ST_HUNT;
          run_d   = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (ev_x) begin
          if (UNLOCK_N == 4'd1) begin
            state_d     = ST_HUNT;
            lock_lost_d = 1'b1;
            run_d       = 4'd0;
          end else begin
            state_d = ST_FLYWHEEL;
            run_d   = 4'd1;
          end
        end
      end
      ST_FLYWHEEL: begin
        if (ev_m) begin
          state_d = ST_LOCKED;
          run_d   = 4'd0;
        end else if (ev_x) begin
          if (run_inc == UNLOCK_N) begin
            state_d     = ST_HUNT;
            lock_lost_d = 1'b1;
            run_d       = 4'd0;
          end else begin
            run_d = run_inc;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        run_d   = 4'd0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_FLYWHEEL);

    // clr wins over a same-cycle increment or protocol error.
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    proto_err_d = proto_err_q | (match & not_match);
    if (clr) begin
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      proto_err_d = 1'b0;
    end else begin
      if (ev_m && match_cnt_q != CNT_MAX) match_cnt_d = match_cnt_q + 1'b1;
      if (ev_x && miss_cnt_q != CNT_MAX)  miss_cnt_d  = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      lock_acq_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      lock_acq_q  <= lock_acq_d;
      lock_lost_q <= lock_lost_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign lock_acq  = lock_acq_q;
  assign lock_lost = lock_lost_q;
  assign match_cnt = match_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign proto_err = proto_err_q;

endmodule
